// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register owner: one-cycle multiply, 32-step restoring divide with pipeline stall
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [4:0] MULT_CONTROL  = 5'd16;
  localparam logic [4:0] MULTU_CONTROL = 5'd17;
  localparam logic [4:0] DIV_CONTROL   = 5'd18;
  localparam logic [4:0] DIVU_CONTROL  = 5'd19;
  localparam logic [4:0] MTHI_CONTROL  = 5'd20;
  localparam logic [4:0] MTLO_CONTROL  = 5'd21;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [4:0]         counter;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   rem, quot, divisor;
  logic               q_neg, r_neg;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial;
  logic               is_div;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign mag_a  = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
  assign mag_b  = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
  // Shift the next dividend bit into the partial remainder and try subtracting.
  assign trial  = {rem, quot[WIDTH-1]} - {1'b0, divisor};
  assign is_div = (alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL);

  always_comb begin
    stall = 1'b0;
    if (!flush) begin
      case (state)
        S_IDLE:  stall = start && is_div;
        S_BUSY:  stall = 1'b1;
        S_FIX:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      counter <= 5'd0;
      hi      <= '0;
      lo      <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (alucontrol)
              MULT_CONTROL:  {hi, lo} <= prod_s;
              MULTU_CONTROL: {hi, lo} <= prod_u;
              MTHI_CONTROL:  hi <= a;
              MTLO_CONTROL:  lo <= a;
              DIV_CONTROL: begin
                quot    <= mag_a;
                divisor <= mag_b;
                q_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg   <= a[WIDTH-1];
                rem     <= '0;
                counter <= 5'd0;
                state   <= S_BUSY;
              end
              DIVU_CONTROL: begin
                quot    <= a;
                divisor <= b;
                q_neg   <= 1'b0;
                r_neg   <= 1'b0;
                rem     <= '0;
                counter <= 5'd0;
                state   <= S_BUSY;
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (!trial[WIDTH]) begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          counter <= counter + 5'd1;
          if (counter == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          lo    <= q_neg ? (WIDTH'(0) - quot) : quot;
          hi    <= r_neg ? (WIDTH'(0) - rem) : rem;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;

  localparam logic [4:0] MULT_CONTROL  = 5'd16;
  localparam logic [4:0] MULTU_CONTROL = 5'd17;
  localparam logic [4:0] DIV_CONTROL   = 5'd18;
  localparam logic [4:0] DIVU_CONTROL  = 5'd19;
  localparam logic [4:0] MTHI_CONTROL  = 5'd20;
  localparam logic [4:0] MTLO_CONTROL  = 5'd21;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        stall;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alucontrol(alucontrol),
    .a(a), .b(b), .flush(flush), .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Inputs change at negedge; outputs are sampled 1ns later, well before posedge.
  task automatic drive(input logic s, input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb, input logic f);
    @(negedge clk);
    start = s; alucontrol = op; a = va; b = vb; flush = f; rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; flush = 1'b0; alucontrol = 5'd0; a = '0; b = '0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
  endtask

  task automatic test_mult(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    drive(1'b1, op, va, vb, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_stall got=%b exp=0", name, stall); end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if ({hi_o, lo_o} !== {exp_hi, exp_lo})
      begin errors++; $display("FAIL %s_result got=%h_%h exp=%h_%h", name, hi_o, lo_o, exp_hi, exp_lo); end
  endtask

  task automatic test_mthi_mtlo();
    drive(1'b1, MTHI_CONTROL, 32'hA5A5_0001, 32'd0, 1'b0);
    drive(1'b1, MTLO_CONTROL, 32'h5A5A_0002, 32'd0, 1'b0);
    checks++; if (hi_o !== 32'hA5A5_0001) begin errors++; $display("FAIL mthi got=%h exp=a5a50001", hi_o); end
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 32'd9, 1'b0);
    checks++; if ({hi_o, lo_o} !== {32'hA5A5_0001, 32'h5A5A_0002})
      begin errors++; $display("FAIL mtlo got=%h_%h exp=a5a50001_5a5a0002", hi_o, lo_o); end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if ({hi_o, lo_o} !== {32'hA5A5_0001, 32'h5A5A_0002} || stall !== 1'b0)
      begin errors++; $display("FAIL other_op got=%h_%h stall=%b exp=a5a50001_5a5a0002 stall=0", hi_o, lo_o, stall); end
  endtask

  // hold_start keeps start asserted with scrambled operands until the DONE cycle.
  task automatic test_div(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit hold_start, input string name);
    int cnt;
    bit done;
    cnt = 0; done = 0;
    drive(1'b1, op, va, vb, 1'b0);
    if (stall === 1'b1) cnt++;
    for (int i = 0; i < 100 && !done; i++) begin
      if (hold_start) drive(1'b1, op, va ^ 32'h0F0F_0F0F, vb + 32'd3, 1'b0);
      else            drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      if (stall === 1'b1) cnt++; else done = 1;
    end
    checks++; if (!done || cnt != 34) begin errors++; $display("FAIL %s_stall_cycles got=%0d exp=34", name, cnt); end
    checks++; if ({hi_o, lo_o} !== {exp_hi, exp_lo})
      begin errors++; $display("FAIL %s_result got=%h_%h exp=%h_%h", name, hi_o, lo_o, exp_hi, exp_lo); end
    if (hold_start) begin
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_no_reaccept got=%b exp=0", name, stall); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, MTHI_CONTROL, 32'h1111_1111, 32'd0, 1'b0);
    drive(1'b1, MTLO_CONTROL, 32'h2222_2222, 32'd0, 1'b0);
    drive(1'b1, DIV_CONTROL, 32'd1000, 32'd3, 1'b0);
    for (int i = 1; i < 10; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_busy_stall got=%b exp=1", stall); end
    drive(1'b1, DIV_CONTROL, 32'd1000, 32'd3, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
    drive(1'b1, MTLO_CONTROL, 32'h0000_1234, 32'd0, 1'b0);
    checks++; if (stall !== 1'b0 || {hi_o, lo_o} !== {32'h1111_1111, 32'h2222_2222})
      begin errors++; $display("FAIL flush_keep got=%h_%h stall=%b exp=11111111_22222222 stall=0", hi_o, lo_o, stall); end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if ({hi_o, lo_o} !== {32'h1111_1111, 32'h0000_1234})
      begin errors++; $display("FAIL flush_mtlo got=%h_%h exp=11111111_00001234", hi_o, lo_o); end
    for (int i = 0; i < 40; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if ({hi_o, lo_o} !== {32'h1111_1111, 32'h0000_1234})
      begin errors++; $display("FAIL flush_dropped got=%h_%h exp=11111111_00001234", hi_o, lo_o); end
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, MTHI_CONTROL, 32'h3333_3333, 32'd0, 1'b0);
    drive(1'b1, DIVU_CONTROL, 32'd77, 32'd5, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (stall !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0)
      begin errors++; $display("FAIL reset_mid_div got=%h_%h stall=%b exp=0_0 stall=0", hi_o, lo_o, stall); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alucontrol = 5'd0; a = '0; b = '0;
    test_reset();
    test_mult(MULT_CONTROL,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    test_mult(MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    test_mult(MULT_CONTROL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1");
    test_mthi_mtlo();
    test_div(DIVU_CONTROL, 32'd100,        32'd7,        32'd2,         32'd14,        0, "divu_100_7");
    test_div(DIV_CONTROL,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_m7_2");
    test_div(DIV_CONTROL,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, "div_ovf");
    test_div(DIVU_CONTROL, 32'd5,          32'd0,        32'd5,         32'hFFFF_FFFF, 0, "divu_by0");
    test_div(DIV_CONTROL,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'h0000_0001, 0, "div_by0");
    test_div(DIVU_CONTROL, 32'd1000,       32'd9,        32'd1,         32'd111,       1, "divu_held");
    test_flush();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
